// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and counter widths for the brick-breaker
// game controller. The state encoding is visible on the game_ctrl state port
// and is decoded by the renderer and score display, so values are fixed.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SERVE       = 3'd1,
    RUN         = 3'd2,
    PAUSE       = 3'd3,
    LIFE_LOST   = 3'd4,
    LEVEL_CLEAR = 3'd5,
    WON         = 3'd6,
    LOST        = 3'd7
  } game_state_t;

  localparam int LIVES_W = 4;
  localparam int LEVEL_W = 4;

endpackage

// File: rtl/serve_timer.sv
// serve_timer: counts frame_tick pulses while the ball waits to be served.
// Ports: clk/rst (async active-high); clear zeroes the count; enable gates
// counting; frame_tick is one pulse per frame; done pulses combinationally in
// the cycle that carries the SERVE_FRAMES-th tick since the last clear.
module serve_timer #(
  parameter int SERVE_FRAMES = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic frame_tick,
  input  logic enable,
  output logic done
);

  // The count only has to reach SERVE_FRAMES-1: the final tick raises done
  // instead of being stored.
  localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SERVE_FRAMES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    done  = enable && frame_tick && (cnt_q == LAST_CNT);
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && frame_tick) begin
      cnt_d = done ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: top-level brick-breaker sequencer tracking lives, levels and
// remaining bricks, timing the serve in frames and gating ball motion.
// Ports: start_game/pause_toggle/frame_tick/brick_hit pulses and the
// ball_out_of_bounds level in; registered state, counters, ball_enable, and
// serve/level_load pulses plus game_won/game_lost status out.
module game_ctrl
  import game_pkg::*;
#(
  parameter int LIVES        = 3,
  parameter int LEVELS       = 4,
  parameter int BRICK_W      = 6,
  parameter int SERVE_FRAMES = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_game,
  input  logic               pause_toggle,
  input  logic               frame_tick,
  input  logic               ball_out_of_bounds,
  input  logic               brick_hit,
  input  logic [BRICK_W-1:0] bricks_total,
  output logic [2:0]         state,
  output logic [3:0]         lives_left,
  output logic [3:0]         level,
  output logic [BRICK_W-1:0] bricks_left,
  output logic               ball_enable,
  output logic               serve,
  output logic               level_load,
  output logic               game_won,
  output logic               game_lost
);

  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(LEVELS - 1);

  game_state_t        state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [BRICK_W-1:0] bricks_q, bricks_d;
  logic               ball_enable_q, ball_enable_d;
  logic               serve_q, serve_d;
  logic               level_load_q, level_load_d;
  logic               won_q, won_d;
  logic               lost_q, lost_d;

  logic               timer_clear;
  logic               timer_en;
  logic               serve_done;
  logic               run_clear;
  logic [BRICK_W-1:0] bricks_dec;

  // The timer is held cleared outside SERVE, so every entry starts from zero
  // and PAUSE (which never passes through SERVE) cannot disturb it.
  assign timer_clear = (state_q != SERVE);
  assign timer_en    = (state_q == SERVE);

  serve_timer #(
    .SERVE_FRAMES(SERVE_FRAMES)
  ) u_serve_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (timer_clear),
    .frame_tick(frame_tick),
    .enable    (timer_en),
    .done      (serve_done)
  );

  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    level_d      = level_q;
    bricks_d     = bricks_q;
    serve_d      = 1'b0;
    level_load_d = 1'b0;

    // An empty level, or the hit that destroys the last brick, ends the level.
    run_clear  = (bricks_q == '0) || (brick_hit && (bricks_q == BRICK_W'(1)));
    // Saturating decrement so bricks_left never wraps.
    bricks_dec = (brick_hit && (bricks_q != '0)) ? bricks_q - 1'b1 : bricks_q;

    case (state_q)
      IDLE, WON, LOST: begin
        if (start_game) begin
          lives_d      = LIVES_INIT;
          level_d      = '0;
          bricks_d     = bricks_total;
          level_load_d = 1'b1;
          state_d      = SERVE;
        end
      end
      SERVE: begin
        if (serve_done) begin
          serve_d = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // Clear outranks a simultaneous loss; the destroyed brick still counts.
        if (run_clear) begin
          bricks_d = bricks_dec;
          state_d  = LEVEL_CLEAR;
        end else if (ball_out_of_bounds) begin
          state_d = LIFE_LOST;
        end else if (pause_toggle) begin
          state_d = PAUSE;
        end else begin
          bricks_d = bricks_dec;
        end
      end
      PAUSE: begin
        if (pause_toggle) begin
          state_d = RUN;
        end
      end
      LIFE_LOST: begin
        lives_d = (lives_q != '0) ? lives_q - 1'b1 : '0;
        state_d = (lives_q <= LIVES_W'(1)) ? LOST : SERVE;
      end
      LEVEL_CLEAR: begin
        if (level_q == LAST_LEVEL) begin
          state_d = WON;
        end else begin
          level_d      = level_q + 1'b1;
          bricks_d     = bricks_total;
          level_load_d = 1'b1;
          state_d      = SERVE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags follow the next state so they line up with state on output.
    ball_enable_d = (state_d == RUN);
    won_d         = (state_d == WON);
    lost_d        = (state_d == LOST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      lives_q       <= '0;
      level_q       <= '0;
      bricks_q      <= '0;
      ball_enable_q <= 1'b0;
      serve_q       <= 1'b0;
      level_load_q  <= 1'b0;
      won_q         <= 1'b0;
      lost_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      level_q       <= level_d;
      bricks_q      <= bricks_d;
      ball_enable_q <= ball_enable_d;
      serve_q       <= serve_d;
      level_load_q  <= level_load_d;
      won_q         <= won_d;
      lost_q        <= lost_d;
    end
  end

  assign state       = state_q;
  assign lives_left  = lives_q;
  assign level       = level_q;
  assign bricks_left = bricks_q;
  assign ball_enable = ball_enable_q;
  assign serve       = serve_q;
  assign level_load  = level_load_q;
  assign game_won    = won_q;
  assign game_lost   = lost_q;

endmodule
